// File: rtl/spi_flash_master_pkg.sv
// Shared definitions for the SPI flash master: FSM state encoding and SPI mode.
// Imported by the top module and the phase timer.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } spi_state_e;

    // {CPOL, CPHA}: mode 0 idles SCK low and samples on the leading (rising) edge.
    localparam logic [1:0] SPI_MODE = 2'b00;

    localparam int unsigned DIV_WIDTH = 8;

endpackage

// File: rtl/spi_flash_master_if.sv
// IO-strobe bus and flash pin bundle for the SPI flash master.
// The slave modport is the block's view; master is the bus/host and flash side.
interface spi_flash_master_if;

    logic       wr;
    logic       cs_wr;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;
    logic       csn;
    logic       sck;
    logic       mosi;
    logic       miso;

    modport slave (
        input  wr, cs_wr, tx_data, miso,
        output rx_data, busy, done, csn, sck, mosi
    );

    modport master (
        output wr, cs_wr, tx_data, miso,
        input  rx_data, busy, done, csn, sck, mosi
    );

endinterface

// File: rtl/spi_flash_master_timer.sv
// Half-period timer: tick marks the last of every DIV cycles.
// A synchronous clear restarts the count at zero.
module spi_phase_timer
    import spi_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    logic [DIV_WIDTH-1:0] divCnt_q;
    logic [DIV_WIDTH-1:0] divCnt_d;

    always_comb begin
        tick     = (divCnt_q == DIV_WIDTH'(DIV - 1));
        divCnt_d = divCnt_q + 1'b1;
        if (clear || tick) begin
            divCnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_d;
        end
    end

endmodule

// File: rtl/spi_flash_master.sv
// Byte-wide SPI mode-0 master for the serial flash, driven by IO write strobes.
// Every pin and status output comes straight from a register.
module spi_flash_master
    import spi_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic               clk,
    input  logic               reset,
    spi_flash_master_if.slave  bus
);

    spi_state_e state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic [7:0] rxData_q, rxData_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       csn_q, csn_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       phaseTick;
    logic       timerClear;

    assign timerClear = (state_q == IDLE);

    spi_phase_timer #(.DIV(DIV)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timerClear),
        .tick  (phaseTick)
    );

    // miso shifts in at bit 0 on the rising edge; the bit now in bit 7 goes out on the falling edge.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitCnt_d = bitCnt_q;
        rxData_d = rxData_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        csn_d    = csn_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        case (state_q)
            IDLE: begin
                if (bus.cs_wr) begin
                    csn_d = bus.tx_data[0];
                end
                if (bus.wr) begin
                    shift_d  = bus.tx_data;
                    mosi_d   = bus.tx_data[7];
                    bitCnt_d = 3'd0;
                    busy_d   = 1'b1;
                    state_d  = LOW;
                end
            end
            LOW: begin
                if (phaseTick) begin
                    sck_d   = 1'b1;
                    shift_d = {shift_q[6:0], bus.miso};
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (phaseTick) begin
                    sck_d = 1'b0;
                    if (bitCnt_q == 3'd7) begin
                        rxData_d = shift_q;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        mosi_d   = shift_q[7];
                        bitCnt_d = bitCnt_q + 3'd1;
                        state_d  = LOW;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitCnt_q <= '0;
            rxData_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            csn_q    <= 1'b1;
            sck_q    <= SPI_MODE[1];
            mosi_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitCnt_q <= bitCnt_d;
            rxData_q <= rxData_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            csn_q    <= csn_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
        end
    end

    assign bus.rx_data = rxData_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.csn     = csn_q;
    assign bus.sck     = sck_q;
    assign bus.mosi    = mosi_q;

endmodule
